// File: rtl/lsu_data_memory.sv
// Load/store front end over a byte-banked data memory: one request in flight,
// configurable response latency, and error flagging for misaligned/out-of-range/illegal-size accesses.

module lsu_dm_bank #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  // Storage is deliberately left uninitialised across reset.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];
endmodule

module lsu_data_memory #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_write_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_error_o
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept, misal, oor, illegal, err;
  logic [LB-1:0]     lane;
  logic [AW-1:0]     widx;
  logic [NB-1:0]     size_mask, be, we;
  logic [XLEN-1:0]   wsh, rword, rsh, lowmask, ld;
  logic              sbit;
  logic [NB-1:0][7:0] bank_rd;

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = err_q;

  assign accept  = req_valid_i & req_ready_o;
  assign lane    = req_addr_i[LB-1:0];
  assign widx    = req_addr_i[LB +: AW];
  // Any address bit above the array's byte span means out of range (no wrap).
  assign oor     = |(req_addr_i >> (LB + AW));
  assign illegal = (XLEN == 32) && (req_size_i == 2'b11);
  assign err     = oor | misal | illegal;

  always_comb begin
    misal     = 1'b0;
    size_mask = '1;
    lowmask   = '1;
    sbit      = 1'b0;
    case (req_size_i)
      2'b00: begin size_mask = NB'(1);    lowmask = XLEN'(64'hFF);        sbit = rsh[7];  end
      2'b01: begin size_mask = NB'(3);    lowmask = XLEN'(64'hFFFF);      sbit = rsh[15];
                   misal = req_addr_i[0]; end
      2'b10: begin size_mask = NB'(4'hF); lowmask = XLEN'(64'hFFFF_FFFF); sbit = rsh[31];
                   misal = |req_addr_i[1:0]; end
      default: begin size_mask = '1;      lowmask = '1;                   sbit = 1'b0;
                   misal = |req_addr_i[2:0]; end
    endcase
  end

  assign be  = size_mask << lane;
  assign wsh = req_wdata_i << {lane, 3'b000};
  assign we  = {NB{accept & req_write_i & ~err}} & be;

  for (genvar i = 0; i < NB; i++) begin : g_bank
    lsu_dm_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk_i   (clk_i),
      .we_i    (we[i]),
      .addr_i  (widx),
      .wdata_i (wsh[i*8 +: 8]),
      .rdata_o (bank_rd[i])
    );
  end

  assign rword = bank_rd;
  assign rsh   = rword >> {lane, 3'b000};
  // Extension by masking keeps the XLEN=32 word case free of zero-width replication.
  assign ld    = (rsh & lowmask) | ((sbit & ~req_unsigned_i) ? ~lowmask : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (accept) begin
        rdata_d = (err | req_write_i) ? '0 : ld;
        err_d   = err;
        cnt_d   = '0;
        state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
      end
      S_WAIT: if (cnt_q == CW'(LATENCY - 2)) begin
        cnt_d   = '0;
        state_d = S_RESP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule
